// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM state codes,
// opcodes, and the ALUOp / ALUSrcB / PCSource codes the datapath decodes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADDR = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC_R  = 4'd7,
        ST_ALUWB_R = 4'd8,
        ST_EXEC_I  = 4'd9,
        ST_ALUWB_I = 4'd10,
        ST_BRANCH  = 4'd11,
        ST_JUMP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath strobe in one bundle so a state only names what it asserts.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // DECODE dispatch; unsupported opcodes fall back to FETCH.
    function automatic state_e decode_target(input logic [5:0] opcode);
        state_e target;
        case (opcode)
            OP_LW,
            OP_SW:    target = ST_MEMADDR;
            OP_RTYPE: target = ST_EXEC_R;
            OP_BEQ:   target = ST_BRANCH;
            OP_J:     target = ST_JUMP;
            OP_ADDI:  target = ST_EXEC_I;
            default:  target = ST_FETCH;
        endcase
        return target;
    endfunction

    function automatic logic opcode_supported(input logic [5:0] opcode);
        logic ok;
        case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_mem_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_stall_watchdog.sv
// Counts consecutive stalled memory cycles and raises a sticky timeout flag
// once the count reaches STALL_LIMIT (STALL_LIMIT = 0 disables the flag).
module multicycle_control_stall_watchdog #(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);
    localparam logic             WD_EN = (STALL_LIMIT != 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q;
        if (stall) begin
            if (cnt_q >= LIMIT) begin
                cnt_d = LIMIT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Flag rises on the same edge the count lands on the limit.
        if (WD_EN && stall && (cnt_d == LIMIT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath strobes.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic       MemTimeout,
    output logic [3:0] State
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_NONE;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only load when the instruction word is actually on the bus.
                ctrl.ir_write  = MemReady;
                ctrl.pc_write  = MemReady;
                if (MemReady) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = ALUSRCB_IMM_SH2;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = ~opcode_supported(Opcode);
                state_d         = decode_target(Opcode);
            end
            ST_MEMADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (MemReady) begin
                    state_d = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                state_d         = ST_FETCH;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (MemReady) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = ST_ALUWB_R;
            end
            ST_ALUWB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                state_d         = ST_FETCH;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = ST_ALUWB_I;
            end
            ST_ALUWB_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
                state_d        = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUSRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                state_d            = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_d        = ST_FETCH;
            end
            default: begin
                // Unreachable codes drive nothing and rejoin at FETCH.
                state_d = ST_FETCH;
            end
        endcase
    end

    assign mem_stall = is_mem_wait_state(state_q) && !MemReady;

    multicycle_control_stall_watchdog #(
        .STALL_LIMIT(STALL_LIMIT),
        .CNT_W      (CNT_W)
    ) u_stall_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .stall  (mem_stall),
        .timeout(MemTimeout)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign IllegalOp   = ctrl.illegal_op;
    assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level plan model checked
// every cycle, plus hand-computed spot checks along the directed program.
module tb_multicycle_control;

    localparam int LIMIT = 4;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADDR = 3, P_MEMRD = 4,
                   P_MEMWB = 5, P_MEMWR = 6, P_EXEC_R = 7, P_ALUWB_R = 8, P_EXEC_I = 9,
                   P_ALUWB_I = 10, P_BRANCH = 11, P_JUMP = 12;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                           T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000,
                           T_BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       MemReady = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic       RegDst, RegWrite, ALUSrcA, IllegalOp, MemTimeout;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    multicycle_control #(.STALL_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .MemTimeout(MemTimeout), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       ill;
    } outs_t;

    outs_t act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

    int total = 0;
    int bad   = 0;

    // Model: current phase, the phases still planned for this instruction,
    // and the stall count / sticky timeout.
    int  m_phase = P_IDLE;
    int  m_plan[$];
    int  m_cnt = 0;
    bit  m_flag = 1'b0;

    function automatic bit legal_op(input logic [5:0] op);
        return op == T_R || op == T_LW || op == T_SW || op == T_BEQ || op == T_J || op == T_ADDI;
    endfunction

    function automatic outs_t expect_outs(input int ph, input logic mr, input logic [5:0] op);
        outs_t e = '0;
        case (ph)
            P_FETCH:   begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
            P_DECODE:  begin e.srcb = 2'b11; e.ill = !legal_op(op); end
            P_MEMADDR: begin e.srca = 1; e.srcb = 2'b10; end
            P_MEMRD:   begin e.mrd = 1; e.iord = 1; end
            P_MEMWB:   begin e.rw = 1; e.m2r = 1; end
            P_MEMWR:   begin e.mwr = 1; e.iord = 1; end
            P_EXEC_R:  begin e.srca = 1; e.aluop = 2'b10; end
            P_ALUWB_R: begin e.rw = 1; e.rdst = 1; end
            P_EXEC_I:  begin e.srca = 1; e.srcb = 2'b10; end
            P_ALUWB_I: begin e.rw = 1; end
            P_BRANCH:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; end
            P_JUMP:    begin e.pcw = 1; e.pcsrc = 2'b10; end
            default:   ;
        endcase
        return e;
    endfunction

    // Model advance: instruction-level phase plans, wait phases hold on MemReady=0.
    initial begin
        bit waiting;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = P_IDLE;
                m_plan.delete();
                m_cnt   = 0;
                m_flag  = 1'b0;
            end else begin
                waiting = (m_phase == P_FETCH) || (m_phase == P_MEMRD) || (m_phase == P_MEMWR);
                if (waiting && !MemReady) begin
                    if (m_cnt < LIMIT) m_cnt++;
                    if (m_cnt == LIMIT) m_flag = 1'b1;
                end else begin
                    m_cnt = 0;
                end
                if (m_phase == P_IDLE) begin
                    m_phase = P_FETCH;
                end else if (waiting && !MemReady) begin
                    m_phase = m_phase;
                end else if (m_phase == P_FETCH) begin
                    m_phase = P_DECODE;
                end else begin
                    if (m_phase == P_DECODE) begin
                        m_plan.delete();
                        case (Opcode)
                            T_LW:    m_plan = '{P_MEMADDR, P_MEMRD, P_MEMWB};
                            T_SW:    m_plan = '{P_MEMADDR, P_MEMWR};
                            T_R:     m_plan = '{P_EXEC_R, P_ALUWB_R};
                            T_BEQ:   m_plan = '{P_BRANCH};
                            T_J:     m_plan = '{P_JUMP};
                            T_ADDI:  m_plan = '{P_EXEC_I, P_ALUWB_I};
                            default: ;
                        endcase
                    end
                    m_phase = (m_plan.size() > 0) ? m_plan.pop_front() : P_FETCH;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        outs_t exp_o;
        forever begin
            @(negedge clk);
            exp_o = expect_outs(m_phase, MemReady, Opcode);
            total++;
            if (act !== exp_o) begin
                bad++;
                $display("FAIL cyc_outs t=%0t phase=%0d got=%05h want=%05h", $time, m_phase, act, exp_o);
            end
            total++;
            if (State !== 4'(m_phase)) begin
                bad++;
                $display("FAIL cyc_state t=%0t got=%0d want=%0d", $time, State, m_phase);
            end
            total++;
            if (MemTimeout !== m_flag) begin
                bad++;
                $display("FAIL cyc_timeout t=%0t got=%0b want=%0b", $time, MemTimeout, m_flag);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // One clock: inputs applied just after the edge, checks just after the falling edge.
    task automatic cyc(input logic [5:0] op, input logic mr);
        @(posedge clk);
        #2;
        Opcode   = op;
        MemReady = mr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(State), 0);
        chk("rst_outs", 32'(act), 0);
        chk("rst_timeout", 32'(MemTimeout), 0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        // R-type: FETCH, DECODE, EXEC_R, ALUWB_R
        cyc(T_R, 1);   chk("r_fetch_state", 32'(State), 1); chk("r_fetch_irw", 32'(IRWrite), 1); chk("r_fetch_pcw", 32'(PCWrite), 1);
        cyc(T_R, 1);   chk("r_decode_state", 32'(State), 2); chk("r_decode_srcb", 32'(ALUSrcB), 3);
        cyc(T_R, 1);   chk("r_exec_state", 32'(State), 7); chk("r_exec_aluop", 32'(ALUOp), 2);
        cyc(T_R, 1);   chk("r_wb_state", 32'(State), 8); chk("r_wb_regwrite", 32'(RegWrite), 1); chk("r_wb_regdst", 32'(RegDst), 1);
        $display("txn R-type done t=%0t", $time);

        // lw with three stalled MEMRD cycles: 8 cycles total
        cyc(T_LW, 1);  chk("lw_fetch_state", 32'(State), 1);
        cyc(T_LW, 1);  chk("lw_decode_state", 32'(State), 2);
        cyc(T_LW, 1);  chk("lw_addr_state", 32'(State), 3); chk("lw_addr_srcb", 32'(ALUSrcB), 2);
        for (int i = 0; i < 4; i++) begin
            cyc(T_LW, (i == 3) ? 1'b1 : 1'b0);
            chk("lw_memrd_state", 32'(State), 4);
            chk("lw_memrd_rd_iord", 32'({MemRead, IorD}), 3);
        end
        cyc(T_LW, 1);  chk("lw_wb_state", 32'(State), 5); chk("lw_wb_rw_m2r", 32'({RegWrite, MemtoReg}), 3);
        chk("lw_no_timeout", 32'(MemTimeout), 0);
        $display("txn lw done t=%0t", $time);

        // beq
        cyc(T_BEQ, 1); chk("beq_fetch_state", 32'(State), 1);
        cyc(T_BEQ, 1); chk("beq_decode_state", 32'(State), 2);
        cyc(T_BEQ, 1); chk("beq_state", 32'(State), 11); chk("beq_aluop", 32'(ALUOp), 1);
        chk("beq_pcwc", 32'(PCWriteCond), 1); chk("beq_pcsrc", 32'(PCSource), 1);
        $display("txn beq done t=%0t", $time);

        // j
        cyc(T_J, 1);   chk("j_fetch_state", 32'(State), 1);
        cyc(T_J, 1);   chk("j_decode_state", 32'(State), 2);
        cyc(T_J, 1);   chk("j_state", 32'(State), 12); chk("j_pcw", 32'(PCWrite), 1); chk("j_pcsrc", 32'(PCSource), 2);
        $display("txn j done t=%0t", $time);

        // Illegal opcode: one-cycle IllegalOp, back to FETCH
        cyc(T_BAD, 1); chk("ill_fetch_state", 32'(State), 1);
        cyc(T_BAD, 1); chk("ill_decode_state", 32'(State), 2); chk("ill_pulse", 32'(IllegalOp), 1);
        chk("ill_no_writes", 32'({RegWrite, MemWrite}), 0);
        $display("txn illegal done t=%0t", $time);

        // Fetch stall: timeout after four stalled cycles, sticky afterwards
        for (int i = 0; i < LIMIT; i++) begin
            cyc(T_BAD, 0);
            chk("stall_state", 32'(State), 1);
            chk("stall_no_irw", 32'({IRWrite, PCWrite, IllegalOp}), 0);
        end
        chk("stall_timeout_pre", 32'(MemTimeout), 0);
        cyc(T_ADDI, 1); chk("stall_timeout_set", 32'(MemTimeout), 1); chk("stall_release_irw", 32'(IRWrite), 1);
        $display("txn fetch stall done t=%0t", $time);

        // addi
        cyc(T_ADDI, 1); chk("addi_decode_state", 32'(State), 2);
        cyc(T_ADDI, 1); chk("addi_exec_state", 32'(State), 9); chk("addi_exec_src", 32'({ALUSrcA, ALUSrcB}), 6);
        cyc(T_ADDI, 1); chk("addi_wb_state", 32'(State), 10); chk("addi_wb_rw_rd", 32'({RegWrite, RegDst}), 2);
        chk("timeout_sticky", 32'(MemTimeout), 1);
        $display("txn addi done t=%0t", $time);

        // sw stalled in MEMWR, then reset mid-instruction
        cyc(T_SW, 1);  chk("sw_fetch_state", 32'(State), 1);
        cyc(T_SW, 1);  chk("sw_decode_state", 32'(State), 2);
        cyc(T_SW, 1);  chk("sw_addr_state", 32'(State), 3);
        cyc(T_SW, 0);  chk("sw_memwr_state", 32'(State), 6); chk("sw_memwr_wr_iord", 32'({MemWrite, IorD}), 3);
        cyc(T_SW, 0);  chk("sw_memwr_hold", 32'(State), 6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(State), 0);
        chk("midrst_memwrite", 32'(MemWrite), 0);
        chk("midrst_outs", 32'(act), 0);
        chk("midrst_timeout", 32'(MemTimeout), 0);
        $display("txn sw reset done t=%0t", $time);
        @(posedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        cyc(T_R, 1);   chk("post_rst_fetch", 32'(State), 1);
        cyc(T_R, 1);   chk("post_rst_decode", 32'(State), 2);
        cyc(T_R, 1);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. Sits directly upstream of the ALU control decoder.
- Decodes the 6-bit opcode from the instruction register.
- Sequences the fetch, decode, execute, memory and writeback states.
- Drives every datapath strobe, including the 2-bit ALUOp consumed by the ALU control block.
- Adds a memory ready handshake and a stall watchdog.

Parameters:
STALL_LIMIT, 16, consecutive MemReady-low cycles in a memory state before MemTimeout sets; 0 disables the watchdog.
CNT_W, 5, width of the stall counter; must satisfy 2^CNT_W > STALL_LIMIT.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Opcode  in  6  instruction bits [31:26] from the instruction register
MemReady  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU Zero (beq)
IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  register-file write data: 0 = ALUOut, 1 = MDR
RegDst  out  1  destination register: 0 = rt, 1 = rd
RegWrite  out  1  register-file write enable
ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A
ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
ALUOp  out  2  to ALU control: 00 = add, 01 = subtract, 10 = funct-decoded
PCSource  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
IllegalOp  out  1  one-cycle pulse on an unsupported opcode in DECODE
MemTimeout  out  1  sticky watchdog flag
State  out  4  current state code, for debug

Behaviour:
- Reset (rst_n low, async): State = IDLE, stall counter = 0, MemTimeout = 0. All outputs are 0, and IDLE drives all outputs 0.
- IDLE always goes to FETCH on the next edge.
- Outputs are Moore functions of State, except the handshake gating described below. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite assert only in the cycle MemReady=1.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADDR
  - 000000 -> EXEC_R
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 (addi) -> EXEC_I
  - any other opcode -> FETCH, with IllegalOp=1 for that one cycle.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits on MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits on MemReady, then goes to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB_R.
- ALUWB_R: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ALUWB_I.
- ALUWB_I: RegWrite=1, RegDst=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- Cycle counts with MemReady held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Watchdog:
  - The counter increments each cycle the FSM is in FETCH, MEMRD or MEMWR with MemReady=0, and clears otherwise.
  - When the counter reaches STALL_LIMIT, MemTimeout sets and holds until reset. The FSM keeps waiting; no abort.
  - The counter saturates at STALL_LIMIT.
- Opcode is sampled only in DECODE and MEMADDR. Changes in other states have no effect.
- Reset asserted mid-instruction forces IDLE immediately. No partial write strobes remain, because all outputs are 0 in IDLE.
- Unused State encodings recover to FETCH with all outputs 0.

Decomposition:
- Shared package holds:
  - state encodings, 4-bit localparams: IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC_R=7, ALUWB_R=8, EXEC_I=9, ALUWB_I=10, BRANCH=11, JUMP=12
  - opcode constants
  - ALUOp, ALUSrcB and PCSource code constants (also used by the ALU control block and the datapath).
- One sub-module: stall_watchdog (counter plus sticky flag).

Test Plan:
- Reset, then release with MemReady=1: State IDLE -> FETCH next edge; in reset all outputs 0; IRWrite=PCWrite=1 in FETCH.
- Opcode 000000, MemReady=1: 4 cycles FETCH, DECODE, EXEC_R (ALUOp=10), ALUWB_R (RegWrite=1, RegDst=1), then back to FETCH.
- lw (100011) with MemReady low 3 cycles in MEMRD: MemRead and IorD held for 4 cycles; MEMWB gives RegWrite=1, MemtoReg=1; total 8 cycles.
- beq (000100): BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01. j (000010): JUMP shows PCWrite=1, PCSource=10.
- Opcode 111111: DECODE pulses IllegalOp for exactly 1 cycle, next state FETCH, no RegWrite or MemWrite seen.
- STALL_LIMIT=4, MemReady=0 in FETCH: MemTimeout rises after 4 stalled cycles and stays 1 after MemReady returns; rst_n low mid-MEMWR gives IDLE and MemWrite=0 immediately.
